// File: rtl/bounce_generator_pkg.sv
// Shared types and LFSR helpers for the mechanical-switch bounce emulator.
package bounce_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GAP    = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } bounce_state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One step of the 16-bit Galois LFSR; a non-zero state never maps to zero.
  function automatic logic [15:0] lfsr_next(input logic [15:0] value);
    return (value >> 1) ^ (value[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/bounce_generator_lfsr16.sv
// Free-running 16-bit Galois LFSR used as the pseudo-random source for glitch timing.
module lfsr16
  import bounce_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [15:0] o_value
);

  logic [15:0] lfsr_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign o_value = lfsr_q;

endmodule

// File: rtl/bounce_generator.sv
// Switch emulator: drives a requested level, adds an even number of random glitch
// toggles, holds the level quietly for SETTLE_CYCLES and then pulses o_done.
module bounce_generator
  import bounce_pkg::*;
#(
  parameter logic        INIT_LEVEL    = 1'b0,
  parameter int          BOUNCE_EN     = 1,
  parameter int          PAIRS_W       = 2,
  parameter int          GAP_W         = 4,
  parameter int          SETTLE_CYCLES = 64,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req,
  input  logic i_level,
  output logic o_ready,
  output logic o_busy,
  output logic o_done,
  output logic o_bouncy
);

  localparam int GAP_CW = GAP_W + 1;
  localparam int TOG_W  = PAIRS_W + 1;
  localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);

  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("bounce_generator: LFSR_SEED must be non-zero");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("bounce_generator: SETTLE_CYCLES must be at least 1");
  end

  bounce_state_t      state_q, state_d;
  logic               bouncy_q, bouncy_d;
  logic [GAP_CW-1:0]  gap_q, gap_d;
  logic [TOG_W-1:0]   tog_q, tog_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [15:0]        lfsr_val;
  logic               lfsr_unused;

  logic [PAIRS_W-1:0] pairs;
  logic [GAP_CW-1:0]  gap_load;
  logic [SET_W-1:0]   settle_load;

  lfsr16 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_value(lfsr_val)
  );

  // Only the low bits feed decisions; the rest of the state just keeps the sequence long.
  assign lfsr_unused = ^lfsr_val;

  assign pairs       = lfsr_val[PAIRS_W-1:0];
  assign gap_load    = GAP_CW'(lfsr_val[GAP_W-1:0]) + GAP_CW'(1);
  assign settle_load = SET_W'(SETTLE_CYCLES);

  always_comb begin
    state_d  = state_q;
    bouncy_d = bouncy_q;
    gap_d    = gap_q;
    tog_d    = tog_q;
    settle_d = settle_q;
    case (state_q)
      IDLE: begin
        if (i_req) begin
          bouncy_d = i_level;
          settle_d = settle_load;
          tog_d    = '0;
          state_d  = SETTLE;
          // A level change is the only case that earns glitch pairs.
          if ((i_level != bouncy_q) && (BOUNCE_EN != 0) && (pairs != '0)) begin
            tog_d   = {pairs, 1'b0};
            gap_d   = gap_load;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_CW'(1)) begin
          bouncy_d = ~bouncy_q;
          tog_d    = tog_q - TOG_W'(1);
          if (tog_q == TOG_W'(1)) begin
            settle_d = settle_load;
            state_d  = SETTLE;
          end else begin
            gap_d = gap_load;
          end
        end else begin
          gap_d = gap_q - GAP_CW'(1);
        end
      end
      SETTLE: begin
        if (settle_q == SET_W'(1)) begin
          state_d = DONE;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      bouncy_q <= INIT_LEVEL;
    end else begin
      state_q  <= state_d;
      bouncy_q <= bouncy_d;
    end
  end

  // Counters are only meaningful once the FSM has loaded them.
  always_ff @(posedge i_clk) begin
    gap_q    <= gap_d;
    tog_q    <= tog_d;
    settle_q <= settle_d;
  end

  assign o_ready  = (state_q == IDLE);
  assign o_busy   = (state_q == GAP) || (state_q == SETTLE);
  assign o_done   = (state_q == DONE);
  assign o_bouncy = bouncy_q;

endmodule

// File: tb/tb_bounce_generator.sv
// Bench for bounce_generator: randomized requests checked against a schedule model.
module tb_bounce_generator;

  localparam int          S    = 64;
  localparam int          S0   = 8;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic req = 1'b0, lvl = 1'b0;
  logic ready, busy, done, bouncy;
  logic req0 = 1'b0, lvl0 = 1'b0;
  logic ready0, busy0, done0, bouncy0;

  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] m_lfsr;
  logic        exp_b;

  bounce_generator dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_level(lvl),
    .o_ready(ready), .o_busy(busy), .o_done(done), .o_bouncy(bouncy)
  );

  bounce_generator #(.BOUNCE_EN(0), .SETTLE_CYCLES(S0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_req(req0), .i_level(lvl0),
    .o_ready(ready0), .o_busy(busy0), .o_done(done0), .o_bouncy(bouncy0)
  );

  function automatic logic [15:0] nxt(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic logic [15:0] adv(input logic [15:0] v, input int n);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = nxt(r);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_lfsr = rst ? SEED : nxt(m_lfsr);
    #1;
    chk("lfsr", dut.lfsr_val, m_lfsr);
  endtask

  // One full request on the default instance, checked cycle by cycle.
  task automatic do_seq(input logic target, input bit noise);
    int          tog_at[$];
    int          ntog, t, g, j, done_off, edges, last_t;
    logic [15:0] l;
    logic        want, prev_obs;
    chk("ready_before_req", ready, 1);
    ntog = (target != exp_b) ? 2 * int'(m_lfsr[1:0]) : 0;
    t = 0;
    l = m_lfsr;
    for (int i = 0; i < ntog; i++) begin
      g = int'(l[3:0]) + 1;
      t += g;
      tog_at.push_back(t);
      l = adv(m_lfsr, t);
    end
    done_off = t + S;
    prev_obs = bouncy;
    edges    = 0;
    last_t   = 0;
    j        = 0;
    req = 1'b1;
    lvl = target;
    tick();
    req = 1'b0;
    for (int c = 0; c <= done_off + 1; c++) begin
      while (j < ntog && tog_at[j] <= c) j++;
      want = target ^ j[0];
      chk("bouncy", bouncy, want);
      chk("done", done, logic'(c == done_off));
      chk("busy", busy, logic'(c < done_off));
      chk("ready", ready, logic'(c > done_off));
      if (bouncy !== prev_obs) begin
        edges++;
        if (c > 0) begin
          chk("gap_range", logic'((c - last_t) >= 1 && (c - last_t) <= 16), 1);
        end
        last_t = c;
      end
      prev_obs = bouncy;
      if (noise && c <= done_off && (c == 0 || c == done_off || $urandom_range(0, 3) == 0)) begin
        req = 1'b1;
        lvl = 1'($urandom);
      end else begin
        req = 1'b0;
      end
      if (c < done_off + 1) tick();
    end
    req = 1'b0;
    chk("edge_count", edges, ((target != exp_b) ? 1 : 0) + ntog);
    chk("final_level", bouncy, target);
    exp_b = target;
  endtask

  initial begin
    int waited;
    // Reset held for three cycles.
    repeat (3) tick();
    chk("rst_bouncy", bouncy, 0);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_lfsr", dut.lfsr_val, 16'hACE1);
    chk("rst0_bouncy", bouncy0, 0);
    exp_b = 1'b0;
    rst = 1'b0;

    // Clean edge, no bounce, SETTLE_CYCLES=8.
    req0 = 1'b1;
    lvl0 = 1'b1;
    tick();
    req0 = 1'b0;
    for (int c = 0; c <= S0 + 1; c++) begin
      chk("nb_bouncy", bouncy0, 1);
      chk("nb_done", done0, logic'(c == S0));
      chk("nb_busy", busy0, logic'(c < S0));
      chk("nb_ready", ready0, logic'(c > S0));
      if (c < S0 + 1) tick();
    end

    // Bouncy rising request, same-level request, noisy request.
    do_seq(1'b1, 1'b0);
    do_seq(exp_b, 1'b0);
    do_seq(~exp_b, 1'b1);

    // Randomized requests, sometimes back to back.
    repeat (14) begin
      repeat ($urandom_range(0, 4)) begin
        tick();
        chk("idle_ready", ready, 1);
        chk("idle_done", done, 0);
      end
      do_seq(1'($urandom), 1'($urandom));
    end

    // Reset in the middle of a glitch gap.
    if (exp_b != 1'b0) do_seq(1'b0, 1'b0);
    waited = 0;
    while (m_lfsr[1:0] == 2'b00 && waited < 64) begin
      tick();
      waited++;
    end
    chk("mid_rst_wait", logic'(m_lfsr[1:0] != 2'b00), 1);
    req = 1'b1;
    lvl = 1'b1;
    tick();
    req = 1'b0;
    chk("mid_gap_bouncy", bouncy, 1);
    chk("mid_gap_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_bouncy", bouncy, 0);
    chk("abort_ready", ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    exp_b = 1'b0;
    repeat (S + 4) begin
      tick();
      chk("abort_no_done", done, 0);
      chk("abort_quiet", bouncy, 0);
    end
    do_seq(1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
